// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
//
// Purpose:
//   Bundles the control-unit <-> datapath signals of the 16-bit accumulator
//   multicycle machine. The controller is the master: it consumes the
//   instruction register contents and the ALU zero flag and drives every
//   select, load enable, ALU operation and memory strobe.
//
// Signals:
//   IROut         datapath -> ctrl  instruction register contents
//   zero          datapath -> ctrl  ALU zero flag (combinational)
//   ALUOperation  ctrl -> datapath  000 AND, 001 OR, 010 ADD, 011 SUB,
//                                   110 NOT A, 101 pass A, 100 pass B
//   PCSrc         ctrl -> datapath  00 ALU result, 01 branch, 10 jump target
//   ALUSrcB       ctrl -> datapath  00 B reg, 01 const 1, 10 sext IR[11:0]
//   ALUSrcA       ctrl -> datapath  0 PC, 1 A register (R0)
//   PCLoad, IOrD, IRWrite, RegDst, MemToReg, RegWrite, MemRead, MemWrite
//                 ctrl -> datapath  load enables / selects / strobes
//   halted        ctrl -> datapath  illegal-instruction halt status
//
// Modports:
//   master  control unit side
//   slave   datapath side
// -----------------------------------------------------------------------------
interface multicycle_controller_if #(
  parameter int INSTR_W = 16
);

  logic [INSTR_W-1:0] IROut;
  logic               zero;
  logic [2:0]         ALUOperation;
  logic [1:0]         PCSrc;
  logic [1:0]         ALUSrcB;
  logic               ALUSrcA;
  logic               PCLoad;
  logic               IOrD;
  logic               IRWrite;
  logic               RegDst;
  logic               MemToReg;
  logic               RegWrite;
  logic               MemRead;
  logic               MemWrite;
  logic               halted;

  modport master (
    input  IROut,
    input  zero,
    output ALUOperation,
    output PCSrc,
    output ALUSrcB,
    output ALUSrcA,
    output PCLoad,
    output IOrD,
    output IRWrite,
    output RegDst,
    output MemToReg,
    output RegWrite,
    output MemRead,
    output MemWrite,
    output halted
  );

  modport slave (
    output IROut,
    output zero,
    input  ALUOperation,
    input  PCSrc,
    input  ALUSrcB,
    input  ALUSrcA,
    input  PCLoad,
    input  IOrD,
    input  IRWrite,
    input  RegDst,
    input  MemToReg,
    input  RegWrite,
    input  MemRead,
    input  MemWrite,
    input  halted
  );

endinterface

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Purpose:
//   Moore FSM control unit for the 16-bit accumulator-style multicycle
//   datapath. R0 is the accumulator. Instruction format:
//     IR[15:12] opcode, IR[11:0] address/immediate,
//     IR[11:9]  register index, IR[8:0] one-hot TYPEC function field.
//   Outputs depend only on the current state and IR (plus the zero flag,
//   which gates PCLoad in the branch state).
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-low reset (rst==0 resets). While low, every
//        enable/strobe, select and halted is forced to 0 combinationally.
//   bus  multicycle_controller_if.master (IROut, zero in; controls out)
//
// Parameters:
//   INSTR_W  instruction width; only 16 is supported.
//
// Build option:
//   ILLEGAL_TRAP_EN  when defined, an illegal opcode or TYPEC function seen
//                    in ID enters a HALT state (halted=1, no enables) that
//                    is left only through reset. When undefined, illegal
//                    instructions retire as a NOP and halted is tied to 0.
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int INSTR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  multicycle_controller_if.master  bus
);

  if (INSTR_W != 16) begin : g_width_check
    $error("multicycle_controller supports INSTR_W == 16 only");
  end

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_BRZ   = 4'b0100;
  localparam logic [3:0] OP_TYPEC = 4'b1000;
  localparam logic [3:0] OP_ADDI  = 4'b1100;
  localparam logic [3:0] OP_SUBI  = 4'b1101;
  localparam logic [3:0] OP_ANDI  = 4'b1110;
  localparam logic [3:0] OP_ORI   = 4'b1111;

  localparam logic [8:0] FN_MOVETO   = 9'h001;
  localparam logic [8:0] FN_MOVEFROM = 9'h002;
  localparam logic [8:0] FN_ADD      = 9'h004;
  localparam logic [8:0] FN_SUB      = 9'h008;
  localparam logic [8:0] FN_AND      = 9'h010;
  localparam logic [8:0] FN_OR       = 9'h020;
  localparam logic [8:0] FN_NOT      = 9'h040;
  localparam logic [8:0] FN_NOP      = 9'h080;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;
  localparam logic [2:0] ALU_PASSA = 3'b101;
  localparam logic [2:0] ALU_NOTA  = 3'b110;

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [3:0] {
    S_IF, S_ID, S_MRD, S_LWB, S_MWR, S_JMP, S_BRZ, S_IEX, S_CEX, S_WB, S_HALT
  } state_t;
  localparam state_t ILLEGAL_NEXT = S_HALT;
`else
  typedef enum logic [3:0] {
    S_IF, S_ID, S_MRD, S_LWB, S_MWR, S_JMP, S_BRZ, S_IEX, S_CEX, S_WB
  } state_t;
  // Without the trap, an illegal instruction simply retires like a NOP.
  localparam state_t ILLEGAL_NEXT = S_IF;
`endif

  state_t state;
  state_t state_n;

  logic [3:0] opcode;
  logic [8:0] func;
  logic       func_onehot;
  logic       func_exec;
  logic       func_nop;

  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic [1:0] alu_src_b;
  logic       alu_src_a;
  logic       pc_load;
  logic       i_or_d;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       halt_flag;

  // ALU operation for the register-register TYPEC functions.
  function automatic logic [2:0] typec_alu_op(input logic [8:0] f);
    case (f)
      FN_MOVETO:   return ALU_PASSA;
      FN_MOVEFROM: return ALU_PASSB;
      FN_ADD:      return ALU_ADD;
      FN_SUB:      return ALU_SUB;
      FN_AND:      return ALU_AND;
      FN_OR:       return ALU_OR;
      FN_NOT:      return ALU_NOTA;
      default:     return ALU_AND;
    endcase
  endfunction

  // Immediate ops are the four opcodes 11xx; the low two bits select the op.
  function automatic logic [2:0] imm_alu_op(input logic [1:0] sel);
    case (sel)
      2'b00:   return ALU_ADD;
      2'b01:   return ALU_SUB;
      2'b10:   return ALU_AND;
      default: return ALU_OR;
    endcase
  endfunction

  assign opcode = bus.IROut[INSTR_W-1 -: 4];
  assign func   = bus.IROut[8:0];

  // Exactly one function bit: non-zero and clearing the lowest set bit
  // leaves nothing behind.
  assign func_onehot = (func != 9'd0) && ((func & (func - 9'd1)) == 9'd0);
  // Bit 8 carries no function and bit 7 (NOP) needs no execute phase.
  assign func_exec   = func_onehot && !func[8] && !func[7];
  assign func_nop    = (func == FN_NOP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IF;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    alu_op     = ALU_AND;
    pc_src     = 2'b00;
    alu_src_b  = 2'b00;
    alu_src_a  = 1'b0;
    pc_load    = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    halt_flag  = 1'b0;

    case (state)
      // Fetch: read memory at PC into IR while PC <- PC + 1.
      S_IF: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        pc_load   = 1'b1;
        state_n   = S_ID;
      end

      S_ID: begin
        case (opcode)
          OP_LOAD:  state_n = S_MRD;
          OP_STORE: state_n = S_MWR;
          OP_JUMP:  state_n = S_JMP;
          OP_BRZ:   state_n = S_BRZ;
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: state_n = S_IEX;
          OP_TYPEC: begin
            if (func_exec) begin
              state_n = S_CEX;
            end else if (func_nop) begin
              state_n = S_IF;
            end else begin
              state_n = ILLEGAL_NEXT;
            end
          end
          default:  state_n = ILLEGAL_NEXT;
        endcase
      end

      S_MRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        state_n  = S_LWB;
      end

      S_LWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_n    = S_IF;
      end

      // Store data path is fixed to the A register (R0).
      S_MWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        state_n   = S_IF;
      end

      S_JMP: begin
        pc_src  = 2'b10;
        pc_load = 1'b1;
        state_n = S_IF;
      end

      // R0 is passed through the ALU so zero reflects the accumulator.
      S_BRZ: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_PASSA;
        pc_src    = 2'b01;
        pc_load   = bus.zero;
        state_n   = S_IF;
      end

      S_IEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = imm_alu_op(opcode[1:0]);
        state_n   = S_WB;
      end

      S_CEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        alu_op    = typec_alu_op(func);
        state_n   = S_WB;
      end

      // Only MOVETO targets R[IR[11:9]]; every other result lands in R0.
      S_WB: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == OP_TYPEC) && (func == FN_MOVETO);
        state_n   = S_IF;
      end

`ifdef ILLEGAL_TRAP_EN
      S_HALT: begin
        halt_flag = 1'b1;
        state_n   = S_HALT;
      end
`endif

      default: state_n = S_IF;
    endcase
  end

  // Reset masks every output immediately, so a reset landing mid-instruction
  // can never produce a partial register or memory write.
  assign bus.ALUOperation = rst ? alu_op    : 3'b000;
  assign bus.PCSrc        = rst ? pc_src    : 2'b00;
  assign bus.ALUSrcB      = rst ? alu_src_b : 2'b00;
  assign bus.ALUSrcA      = rst & alu_src_a;
  assign bus.PCLoad       = rst & pc_load;
  assign bus.IOrD         = rst & i_or_d;
  assign bus.IRWrite      = rst & ir_write;
  assign bus.RegDst       = rst & reg_dst;
  assign bus.MemToReg     = rst & mem_to_reg;
  assign bus.RegWrite     = rst & reg_write;
  assign bus.MemRead      = rst & mem_read;
  assign bus.MemWrite     = rst & mem_write;
  assign bus.halted       = rst & halt_flag;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM control unit that drives the 16-bit accumulator-style multicycle datapath.
- Consumes the instruction register contents (IR) and the ALU zero flag; produces every mux select, load enable and ALU operation, plus the memory read/write strobes.
- R0 is the accumulator. Instruction format: IR[15:12] opcode, IR[11:0] address/immediate, IR[11:9] register index, IR[8:0] one-hot function field.

Parameters:
INSTR_W, 16, instruction width; only 16 is supported; opcode is IR[INSTR_W-1:INSTR_W-4]

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-low (rst==0 resets)
IROut  input  16  instruction register contents
zero  input  1  ALU zero flag, combinational from datapath
ALUOperation  output  3  000 AND, 001 OR, 010 ADD, 011 SUB, 110 NOT A, 101 pass A, 100 pass B
PCSrc  output  2  00 ALU result, 01 branch target, 10 jump target
ALUSrcB  output  2  00 B register, 01 constant 1, 10 sign-extended IR[11:0]
ALUSrcA  output  1  0 PC, 1 A register (R0)
PCLoad  output  1  PC write enable
IOrD  output  1  0 PC address, 1 IR[11:0] address
IRWrite  output  1  IR load enable
RegDst  output  1  0 write R0, 1 write R[IR[11:9]]
MemToReg  output  1  0 ALU register, 1 MDR
RegWrite  output  1  register file write enable
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
halted  output  1  illegal-instruction halt status

Behaviour:
- Opcodes: LOAD 0000, STORE 0001, JUMP 0010, BRZ 0100, TYPEC 1000, ADDI 1100, SUBI 1101, ANDI 1110, ORI 1111.
- TYPEC function, IR[8:0] one-hot:
  - bit0 MOVETO: R[i] <- R0
  - bit1 MOVEFROM: R0 <- R[i]
  - bit2 ADD, bit3 SUB, bit4 AND, bit5 OR: R0 <- R0 op R[i]
  - bit6 NOT: R0 <- ~R0
  - bit7 NOP
- State register resets to IF. While rst==0, all of PCLoad, IRWrite, RegWrite, MemRead, MemWrite are forced 0 combinationally, all selects are 0, halted is 0.
- Outputs are decoded from the current state plus IR only (Moore). Every output not listed for a state is 0.
- States and outputs:
  - IF: MemRead=1, IOrD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOperation=010, PCSrc=00, PCLoad=1 -> ID
  - ID: no enables; decodes opcode. LOAD->MRD; STORE->MWR; JUMP->JMP; BRZ->BRZ; ADDI/SUBI/ANDI/ORI->IEX; TYPEC with single legal function bit, excluding NOP ->CEX; TYPEC NOP->IF; anything else -> see Optional Feature.
  - MRD: IOrD=1, MemRead=1 -> LWB
  - LWB: MemToReg=1, RegDst=0, RegWrite=1 -> IF
  - MWR: IOrD=1, MemWrite=1; data is A register (R0) -> IF
  - JMP: PCSrc=10, PCLoad=1 -> IF
  - BRZ: ALUSrcA=1, ALUOperation=101, PCSrc=01, PCLoad=zero -> IF
  - IEX: ALUSrcA=1, ALUSrcB=10, ALUOperation=010/011/000/001 for ADDI/SUBI/ANDI/ORI -> WB
  - CEX: ALUSrcA=1, ALUSrcB=00. ALUOperation: MOVETO 101, MOVEFROM 100, ADD 010, SUB 011, AND 000, OR 001, NOT 110 -> WB
  - WB: MemToReg=0, RegWrite=1, RegDst=1 only for TYPEC MOVETO, else 0 -> IF
- Latency in cycles: LOAD 4, STORE 3, JUMP 3, BRZ 3, immediate 4, TYPEC 4, NOP 2.
- IR is stable from ID to the end of the instruction because IRWrite is asserted only in IF.
- TYPEC with zero or more than one function bit set is illegal.
- Reset asserted mid-instruction: next edge returns to IF; no partial write occurs while rst==0.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an illegal opcode or function in ID -> HALT state. In HALT, all enables are 0 and halted=1; the FSM stays in HALT until reset.
- Undefined: illegal instructions behave as NOP (ID->IF); no HALT state exists; halted is tied to 0.

Test Plan:
- Reset: rst=0 for 2 cycles with IROut=0x2005 -> all enables 0. First cycle after rst=1: IF outputs (MemRead=1, IRWrite=1, PCLoad=1, ALUSrcB=01, ALUOperation=010).
- LOAD 0x0123: states IF,ID,MRD,LWB. IOrD=1 with MemRead=1 in cycle 3; RegWrite=1, MemToReg=1, RegDst=0 in cycle 4; IF in cycle 5.
- BRZ 0x4010: zero=1 -> PCLoad=1, PCSrc=01 in cycle 3. Repeat with zero=0 -> PCLoad=0; next cycle is IF.
- TYPEC MOVETO 0x8601 -> cycle 3 ALUOperation=101; cycle 4 RegWrite=1, RegDst=1. SUB 0x8208 -> ALUOperation=011, RegDst=0.
- SUBI 0xDFFF -> ALUSrcB=10, ALUOperation=011, then RegWrite=1. STORE 0x1040 -> MemWrite=1, IOrD=1 in cycle 3, no RegWrite.
- IROut=0x3000: with ILLEGAL_TRAP_EN, halted=1 from cycle 3 and stays set; no enables for 10 cycles; cleared by rst=0. Without the macro, IF follows ID and halted stays 0.
